// File: rtl/imem_responder.sv
// imem_responder
//   Responder side of the instruction-fetch interface. Accepts fetch requests,
//   reads a 32-bit word from on-chip program memory, and returns it LATENCY
//   cycles later through a valid/ready response channel fed by a small FIFO.
//   A side write port loads the program image; flush drops everything in flight.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-low reset
//   req_valid/req_ready/req_addr fetch request channel (byte address)
//   resp_valid/resp_ready        response handshake
//   resp_inst/resp_addr/resp_err response payload (FIFO head)
//   flush                        discard in-flight and queued responses
//   wr_en/wr_addr/wr_data        program-load write port
module imem_responder #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_inst,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int unsigned IW         = $clog2(DEPTH);
  localparam int unsigned PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FIFO_SLOTS = 1 << PW;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0]     MAX_OUT    = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);
  localparam logic [DATA_W-1:0] NOP_INST   = DATA_W'(32'h0000_0013);

  typedef struct packed {
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] inst;
  } ent_t;

  logic [DATA_W-1:0] mem [DEPTH];
  ent_t              fifo_q [FIFO_SLOTS];

  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [CW-1:0] outstanding;

  logic accept;
  logic pop;
  logic push_v;
  ent_t in_e;
  ent_t push_e;
  ent_t head;

  assign req_ready = rst & ~flush & (outstanding < MAX_OUT);
  assign accept    = req_valid & req_ready;

  always_comb begin
    in_e      = '0;
    in_e.addr = req_addr;
    in_e.err  = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
    in_e.inst = in_e.err ? NOP_INST : mem[req_addr[IW+1:2]];
  end

  // Program load; the fetch path samples mem before this update lands, which
  // gives read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < ADDR_LIMIT)) begin
      mem[wr_addr[IW+1:2]] <= wr_data;
    end
  end

  // The read at the accept edge is the first registered stage; with
  // LATENCY == 1 the read result goes straight into the FIFO.
  if (LATENCY == 1) begin : g_direct
    assign push_v = accept;
    assign push_e = in_e;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv;
    ent_t               pe [LATENCY-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pv <= '0;
      end else if (flush) begin
        pv <= '0;
      end else begin
        pv[0] <= accept;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          pv[i] <= pv[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      pe[0] <= in_e;
      for (int unsigned i = 1; i < LATENCY - 1; i++) begin
        pe[i] <= pe[i-1];
      end
    end

    assign push_v = pv[LATENCY-2];
    assign push_e = pe[LATENCY-2];
  end

  assign resp_valid = (wr_ptr != rd_ptr) & ~flush;
  assign pop        = resp_valid & resp_ready;
  assign head       = fifo_q[rd_ptr[PW-1:0]];
  assign resp_inst  = head.inst;
  assign resp_addr  = head.addr;
  assign resp_err   = head.err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push_v) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (PW+1)'(1);
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Outstanding-credit gating bounds FIFO occupancy, so no full check here.
  always_ff @(posedge clk) begin
    if (push_v && !flush) begin
      fifo_q[wr_ptr[PW-1:0]] <= push_e;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic [31:0] resp_addr;
  logic        resp_err;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_err    = 0;

  imem_responder #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(512), .LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_inst(resp_inst), .resp_addr(resp_addr), .resp_err(resp_err),
    .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    next();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_q [4];
    logic [31:0] e_addr [3];
    logic [31:0] e_inst [3];
    logic        e_err [3];
    int          accepts;

    exp_q  = '{32'h11, 32'h22, 32'h33, 32'h44};
    e_addr = '{32'h2, 32'h800, 32'h7FC};
    e_inst = '{32'h13, 32'h13, 32'hDEAD_BEEF};
    e_err  = '{1'b1, 1'b1, 1'b0};

    rst = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    next();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    next();

    // program load; the 0x800 write is out of range and must be dropped
    write_word(32'h0, 32'h11);
    write_word(32'h800, 32'hBAD);
    write_word(32'h4, 32'h22);
    write_word(32'h8, 32'h33);
    write_word(32'hC, 32'h44);
    write_word(32'h7FC, 32'hDEAD_BEEF);

    // back-to-back fetches, response two cycles after the request cycle
    resp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4);
      req_addr  = 32'(c * 4);
      @(negedge clk);
      if (c < 4) check("t1_req_ready", req_ready, 1);
      if (c < 2 || c > 5) begin
        check("t1_idle", resp_valid, 0);
      end else begin
        check("t1_valid", resp_valid, 1);
        check("t1_inst", resp_inst, exp_q[c-2]);
        check("t1_addr", resp_addr, 32'((c - 2) * 4));
        check("t1_err", resp_err, 0);
      end
      next();
    end
    req_valid = 1'b0;

    // back-pressure: exactly four accepts, head held stable
    resp_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 7; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'((c % 4) * 4);
      @(negedge clk);
      if (req_valid && req_ready) accepts++;
      if (c >= 2) begin
        check("t2_hold_valid", resp_valid, 1);
        check("t2_hold_inst", resp_inst, 32'h11);
      end
      next();
    end
    check("t2_accepts", 64'(accepts), 4);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      if (d == 0) check("t2_full_ready", req_ready, 0);
      if (d == 1) check("t2_credit_back", req_ready, 1);
      if (d < 4) begin
        check("t2_drain_valid", resp_valid, 1);
        check("t2_drain_inst", resp_inst, exp_q[d]);
      end else begin
        check("t2_drain_empty", resp_valid, 0);
      end
      next();
    end

    // misaligned, out-of-range, and last valid word
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 3);
      req_addr  = (c < 3) ? e_addr[c] : 32'h0;
      @(negedge clk);
      if (c >= 2 && c < 5) begin
        check("t3_valid", resp_valid, 1);
        check("t3_inst", resp_inst, e_inst[c-2]);
        check("t3_addr", resp_addr, e_addr[c-2]);
        check("t3_err", resp_err, e_err[c-2]);
      end else begin
        check("t3_idle", resp_valid, 0);
      end
      next();
    end
    req_valid = 1'b0;

    // flush with three in flight
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'(c * 4);
      next();
    end
    req_addr = 32'hC;
    flush    = 1'b1;
    @(negedge clk);
    check("t4_flush_ready", req_ready, 0);
    check("t4_flush_valid", resp_valid, 0);
    next();
    flush    = 1'b0;
    req_addr = 32'h4;
    @(negedge clk);
    check("t4_after_valid", resp_valid, 0);
    check("t4_after_ready", req_ready, 1);
    next();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("t4_wait_valid", resp_valid, 0);
    next();
    @(negedge clk);
    check("t4_resp_valid", resp_valid, 1);
    check("t4_resp_inst", resp_inst, 32'h22);
    check("t4_resp_addr", resp_addr, 32'h4);
    next();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t4_no_stale", resp_valid, 0);
      next();
    end

    // read-before-write on a same-word collision
    wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'hAB;
    req_valid = 1'b1; req_addr = 32'h4;
    next();
    wr_en = 1'b0;
    next();
    req_valid = 1'b0;
    @(negedge clk);
    check("t5_old_valid", resp_valid, 1);
    check("t5_old_inst", resp_inst, 32'h22);
    next();
    @(negedge clk);
    check("t5_new_valid", resp_valid, 1);
    check("t5_new_inst", resp_inst, 32'hAB);
    next();
    @(negedge clk);
    check("t5_empty", resp_valid, 0);
    next();

    // reset mid-stream with two outstanding
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    next();
    req_addr = 32'h4;
    next();
    req_valid = 1'b0;
    @(negedge clk);
    check("t6_pre_valid", resp_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_valid", resp_valid, 0);
    check("t6_rst_ready", req_ready, 0);
    next();
    rst = 1'b1;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_no_stale", resp_valid, 0);
      check("t6_ready", req_ready, 1);
      next();
    end
    req_valid = 1'b1; req_addr = 32'h0;
    next();
    req_valid = 1'b0;
    next();
    @(negedge clk);
    check("t6_mem_valid", resp_valid, 1);
    check("t6_mem_inst", resp_inst, 32'h11);
    check("t6_mem_addr", resp_addr, 32'h0);
    next();
    @(negedge clk);
    check("t6_end_empty", resp_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder side of the instruction-fetch interface: accepts fetch requests, reads a 32-bit instruction word from on-chip program memory, and returns it after a fixed latency through a valid/ready response channel backed by a small output FIFO.
- Sits between the fetch stage and program storage.
- Supports front-end flush on branch redirect and a side write port used to load the program image.

Parameters:
- DATA_W, 32, instruction width.
- ADDR_W, 32, byte-address width.
- DEPTH, 512, memory size in words (power of 2).
- LATENCY, 2, accept-to-response latency in cycles, legal range 1..4.
- FIFO_DEPTH, 4, response FIFO entries; also the max outstanding requests (power of 2, >= LATENCY).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept.
- req_addr  in  ADDR_W  byte address of the fetch.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_inst  out  DATA_W  instruction word.
- resp_addr  out  ADDR_W  address echoed from the request.
- resp_err  out  1  misaligned or out-of-range fetch.
- flush  in  1  discard all in-flight and queued responses.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  ADDR_W  byte address for the write (word-aligned; bits [1:0] ignored).
- wr_data  in  DATA_W  write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pipeline valid bits, FIFO pointers and outstanding counter clear.
  - resp_valid=0, req_ready=0 while rst is low.
  - req_ready=1 from the first cycle after release.
  - Memory contents are not reset.
- Acceptance:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - req_ready = rst & !flush & (outstanding < FIFO_DEPTH), combinational.
  - outstanding counts accepted-but-not-popped requests: increments on accept, decrements on pop, both in the same cycle leave it unchanged.
- Word index = req_addr[log2(DEPTH)+1:2].
- Error conditions:
  - Misaligned: req_addr[1:0] != 0.
  - Out of range: req_addr >= DEPTH*4.
  - Either condition gives resp_err=1 and resp_inst=32'h00000013 (NOP); the memory is not read.
- Latency:
  - Memory is read at the acceptance edge.
  - The result travels through LATENCY-1 registered stages, each with a valid bit, then is pushed into the FIFO.
  - A request accepted at edge t with an empty FIFO shows resp_valid=1 in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after the request cycle.
  - Back-to-back accepts give one response per cycle.
- Response channel:
  - resp_valid = FIFO non-empty.
  - Pop on resp_valid & resp_ready.
  - resp_inst, resp_addr and resp_err reflect the FIFO head and stay stable while resp_valid & !resp_ready.
  - Responses are returned in request order.
  - Credit gating guarantees the FIFO never overflows; a push and a pop when full in the same cycle are legal.
- Flush:
  - In the flush cycle all pipeline valids clear, FIFO pointers reset and outstanding goes to 0 at the edge.
  - resp_valid is forced 0 during the flush cycle; no pop occurs.
  - req_ready is 0, so a request presented with flush is not accepted.
  - The next request is accepted the following cycle.
- Write port:
  - wr_en writes mem[wr_addr word index] at the edge; out-of-range writes are dropped.
  - A read accepted in the same cycle to the same word returns the old data (read-before-write).
  - A write does not affect req_ready.
- Response values are undefined when resp_valid=0.

Test Plan:
- Reset release, load mem[0..3]=0x11,0x22,0x33,0x44 via wr_en, then request 0x0,0x4,0x8,0xC back-to-back with resp_ready=1 and LATENCY=2 -> resp_valid rises 2 cycles after the first request; responses 0x11,0x22,0x33,0x44 on consecutive cycles with matching resp_addr and resp_err=0.
- resp_ready=0 while issuing requests continuously -> exactly FIFO_DEPTH=4 accepts, then req_ready=0. Raise resp_ready -> head 0x11 held stable until popped; req_ready returns the cycle after the first pop.
- Requests to 0x2 and 0x800 (DEPTH=512) -> both responses carry resp_err=1 and resp_inst=0x00000013.
- Fill 3 entries, assert flush with req_valid=1 for one cycle -> resp_valid=0 in the flush cycle and after; the request is not accepted. A new request to 0x4 next cycle returns 0x22 only.
- Same-cycle write mem[1]=0xAB and fetch 0x4 -> response 0x22. A following fetch to 0x4 -> 0xAB.
- Assert rst low mid-stream with 2 outstanding -> resp_valid and req_ready drop immediately. After release, no stale responses appear and mem[0] still reads 0x11.
